// File: rtl/hier_leaf_stream_stage.sv
// hier_leaf_stream_stage
// Leaf stage: small valid/ready FIFO with a registered head, a running XOR
// checksum of forwarded beats and a drain-on-request flush sequencer.
// Optional feature macro: HIER_LEAF_PARITY_EN adds per-entry parity storage,
// a registered out_parity and a sticky parity_err flag.
module hier_leaf_stream_stage #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int LEAF_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DATA_W-1:0]          checksum,
    output logic [7:0]                 leaf_id
`ifdef HIER_LEAF_PARITY_EN
    ,
    output logic                       out_parity,
    output logic                       parity_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              done_next;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_next;
    logic [LW-1:0]     level_next;
    logic [DATA_W-1:0] head_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    // In DONE the stage stays closed until flush_req is released, so a held
    // request cannot let new beats sneak in behind a completed drain.
    assign in_ready  = rst_n && (state == RUN) && !flush_req &&
                       ((level < LW'(DEPTH)) || out_ready);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign leaf_id   = 8'(LEAF_ID);

    // Flush sequencer next state and the done pulse request.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            RUN: begin
                if (flush_req) begin
                    if (level == '0) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((level == '0) || ((level == LW'(1)) && pop)) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!flush_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Next read pointer, occupancy and head value; a beat written into the
    // slot that becomes the head is forwarded straight from in_data.
    always_comb begin
        rd_next = pop ? rd_ptr + PW'(1) : rd_ptr;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
        if (push && (wr_ptr == rd_next)) head_next = in_data;
        else                             head_next = mem[rd_next];
    end

    // Control, head register and checksum; all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_data   <= '0;
            checksum   <= '0;
        end else begin
            state      <= state_next;
            flush_done <= done_next;
            level      <= level_next;
            rd_ptr     <= rd_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  checksum <= checksum ^ out_data;
            out_data   <= (level_next == '0) ? '0 : head_next;
        end
    end

    // Payload storage carries no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef HIER_LEAF_PARITY_EN
    logic mem_par [DEPTH];
    logic par_next;

    // Parity of the entry that becomes the head, bypassed like the data.
    always_comb begin
        if (push && (wr_ptr == rd_next)) par_next = ^in_data;
        else                             par_next = mem_par[rd_next];
    end

    // Parity storage written alongside the payload.
    always_ff @(posedge clk) begin
        if (push) mem_par[wr_ptr] <= ^in_data;
    end

    // Registered head parity and sticky readout mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            out_parity <= (level_next == '0) ? 1'b0 : par_next;
            if (pop && ((^out_data) != out_parity)) parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hier_leaf_stream_stage.sv
// tb_hier_leaf_stream_stage
// Randomized and directed stimulus; a queue-based reference model predicts
// occupancy, ordering, checksum and flush behaviour, and a monitor compares.
module tb_hier_leaf_stream_stage;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int LEAF_ID = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              flush_req = 1'b0;
    logic              flush_done;
    logic [2:0]        level;
    logic [DATA_W-1:0] checksum;
    logic [7:0]        leaf_id;
`ifdef HIER_LEAF_PARITY_EN
    logic              out_parity;
    logic              parity_err;
`endif

    hier_leaf_stream_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEAF_ID(LEAF_ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .level(level), .checksum(checksum), .leaf_id(leaf_id)
`ifdef HIER_LEAF_PARITY_EN
        , .out_parity(out_parity), .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic cks_probe = 1'b0;
    logic [DATA_W-1:0] cks_want = '0;

    // model state: queue of stored beats, flush phase (0 run,1 drain,2 done)
    logic [DATA_W-1:0] mq[$];
    int                mph = 0;
    logic [DATA_W-1:0] mcks = '0;
    logic              mdone = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard: compare, then advance the model across the next edge
    always @(negedge clk) begin
        logic m_ir, m_pop, m_push, nxt_done;
        int   sz;
        if (!rst_n) begin
            check("rst_level", level, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_checksum", checksum, 0);
            check("rst_flush_done", flush_done, 0);
`ifdef HIER_LEAF_PARITY_EN
            check("rst_out_parity", out_parity, 0);
            check("rst_parity_err", parity_err, 0);
`endif
            mq.delete();
            mph   = 0;
            mcks  = '0;
            mdone = 1'b0;
        end else begin
            sz   = mq.size();
            m_ir = (mph == 0) && !flush_req && ((sz < DEPTH) || out_ready);
            check("in_ready", in_ready, m_ir);
            check("out_valid", out_valid, sz != 0);
            check("level", level, sz);
            check("checksum", checksum, mcks);
            check("flush_done", flush_done, mdone);
            check("leaf_id", leaf_id, LEAF_ID);
            if (cks_probe) check("checksum_directed", checksum, cks_want);
            if (sz != 0) begin
                check("out_data", out_data, mq[0]);
`ifdef HIER_LEAF_PARITY_EN
                check("out_parity", out_parity, ^mq[0]);
`endif
            end
`ifdef HIER_LEAF_PARITY_EN
            check("parity_err", parity_err, 0);
`endif
            m_pop    = (sz != 0) && out_ready;
            m_push   = in_valid && m_ir;
            nxt_done = 1'b0;
            case (mph)
                0: if (flush_req) begin
                       if (sz == 0) begin nxt_done = 1'b1; mph = 2; end
                       else mph = 1;
                   end
                1: if (sz == 0 || (sz == 1 && m_pop)) begin nxt_done = 1'b1; mph = 2; end
                default: if (!flush_req) mph = 0;
            endcase
            mdone = nxt_done;
            if (m_pop) begin
                mcks = mcks ^ mq[0];
                void'(mq.pop_front());
            end
            if (m_push) mq.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fl_cnt;
        // reset then idle
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // fill to full with the sink stalled, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 8'h11);
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (5) step();
        cks_want  = 8'h44;
        cks_probe = 1'b1;
        step();
        cks_probe = 1'b0;

        // continuous streaming, 16 incrementing beats
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // fill 3 beats, then flush while upstream still offers data
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            step();
        end
        in_data   = 8'hEE;
        flush_req = 1'b1;
        out_ready = 1'b1;
        repeat (8) step();
        flush_req = 1'b0;
        in_valid  = 1'b0;
        repeat (2) step();

        // flush with empty FIFO
        flush_req = 1'b1;
        repeat (3) step();
        flush_req = 1'b0;
        repeat (2) step();

        // reset in the middle of a drain holding two beats
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            step();
        end
        in_valid  = 1'b0;
        flush_req = 1'b1;
        repeat (2) step();
        rst_n     = 1'b0;
        flush_req = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

`ifdef HIER_LEAF_PARITY_EN
        // parity of odd and even weight bytes
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h07;
        step();
        in_data   = 8'h03;
        step();
        in_valid  = 1'b0;
        repeat (2) step();
`endif

        // randomized traffic with occasional flush requests
        fl_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            in_data   = 8'($urandom);
            if (fl_cnt > 0) fl_cnt--;
            else if ($urandom_range(0, 40) == 0) fl_cnt = $urandom_range(1, 8);
            flush_req = (fl_cnt > 0);
            step();
        end
        in_valid  = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
